// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU datapath: bus words, PC-source select and
// fetch-unit state encoding, plus the branch displacement helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        PC_SEQ = 3'd0,
        PC_BR  = 3'd1,
        PC_J   = 3'd2,
        PC_JR  = 3'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Sign-extended 16-bit immediate scaled to a byte offset (word count << 2).
    function automatic word_t branch_offset(input word_t ir);
        return {{14{ir[15]}}, ir[15:0], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump
// and jump-register. Encodings 4-7 of the select fall back to sequential.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t       pc_i,
    input  word_t       ir_i,
    input  logic [2:0]  pcsrc_i,
    input  logic        beq_i,
    input  logic        zero_i,
    input  word_t       jr_target_i,
    output word_t       pc_plus4_o,
    output word_t       next_pc_o
);

    word_t pc_plus4_s;
    logic  taken_s;

    assign pc_plus4_s = pc_i + 32'd4;
    assign pc_plus4_o = pc_plus4_s;

    // Select the next PC; all additions wrap modulo 2^32.
    always_comb begin
        next_pc_o = pc_plus4_s;
        taken_s   = 1'b0;
        if (beq_i) begin
            taken_s = zero_i;
        end else begin
            taken_s = !zero_i;
        end
        case (pcsrc_i)
            PC_BR: begin
                if (taken_s) begin
                    next_pc_o = pc_plus4_s + branch_offset(ir_i);
                end else begin
                    next_pc_o = pc_plus4_s;
                end
            end
            PC_J:    next_pc_o = {pc_plus4_s[31:28], ir_i[25:0], 2'b00};
            PC_JR:   next_pc_o = jr_target_i;
            default: next_pc_o = pc_plus4_s;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC and instruction register, sequences
// FETCH -> EXEC (-> MEM) -> FETCH, and parks in HALT until reset.
module instruction_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  word_t       iload,
    output logic        iREN,
    output word_t       iaddr,
    output word_t       imemload,
    output logic        instr_valid,
    input  logic [2:0]  PCSrc,
    input  logic        beq,
    input  logic        zero,
    input  word_t       jr_target,
    input  logic        mem_op,
    input  logic        dhit,
    input  logic        halt,
    output word_t       pc_plus4,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        ir_q, ir_d;
    logic         halted_q, halted_d;
    word_t        next_pc_s;

    next_pc_calc u_next_pc (
        .pc_i        (pc_q),
        .ir_i        (ir_q),
        .pcsrc_i     (PCSrc),
        .beq_i       (beq),
        .zero_i      (zero),
        .jr_target_i (jr_target),
        .pc_plus4_o  (pc_plus4),
        .next_pc_o   (next_pc_s)
    );

    // State, PC, IR and halt flag registers; reset overrides every transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= FETCH;
            pc_q     <= PC_INIT;
            ir_q     <= 32'h0000_0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic; PC only moves on commit, IR only loads in FETCH.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    ir_d    = iload;
                    state_d = EXEC;
                end else begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                if (halt) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (mem_op && !dhit) begin
                    state_d = MEM;
                end else begin
                    pc_d    = next_pc_s;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (dhit) begin
                    pc_d    = next_pc_s;
                    state_d = FETCH;
                end else begin
                    state_d = MEM;
                end
            end
            HALT: begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign iREN        = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC) || (state_q == MEM);
    assign iaddr       = pc_q;
    assign imemload    = ir_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized instruction streams checked against a behavioural PC model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] imemload;
    logic        instr_valid;
    logic [2:0]  PCSrc = 3'd0;
    logic        beq = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        mem_op = 1'b0;
    logic        dhit = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc_plus4;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc = PC_INIT;
    logic [31:0] exp_ir = 32'h0;

    instruction_fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN),
        .iaddr(iaddr), .imemload(imemload), .instr_valid(instr_valid),
        .PCSrc(PCSrc), .beq(beq), .zero(zero), .jr_target(jr_target),
        .mem_op(mem_op), .dhit(dhit), .halt(halt), .pc_plus4(pc_plus4),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference next-PC computed from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                               input logic [2:0] src, input logic bq,
                                               input logic zr, input logic [31:0] jt);
        logic [31:0] p4;
        logic [15:0] imm;
        int          off;
        logic        tk;
        p4  = pc + 32'd4;
        imm = ir[15:0];
        off = int'($signed(imm)) * 4;
        tk  = bq ? zr : !zr;
        case (src)
            3'd1:    return tk ? (p4 + 32'(off)) : p4;
            3'd2:    return (p4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            3'd3:    return jt;
            default: return p4;
        endcase
    endfunction

    task automatic apply_reset();
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; halt = 1'b0; mem_op = 1'b0;
        step();
        step();
        RST = 1'b0;
        exp_pc = PC_INIT;
        exp_ir = 32'h0;
    endtask

    // Run one instruction through fetch/exec/mem, checking each cycle.
    task automatic do_instr(input logic [31:0] word, input int nf, input logic [2:0] src,
                            input logic bq, input logic zr, input logic [31:0] jt,
                            input logic mop, input int nm, input logic hlt, input logic stray);
        checks++;
        if (iREN !== 1'b1 || iaddr !== exp_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_entry: iREN=%b iaddr=%h valid=%b want 1 %h 0", iREN, iaddr, instr_valid, exp_pc);
        end
        for (int i = 0; i < nf; i++) begin
            ihit = 1'b0; iload = $urandom; dhit = 1'($urandom); halt = 1'b0;
            step();
            checks++;
            if (iREN !== 1'b1 || imemload !== exp_ir || iaddr !== exp_pc) begin
                errors++;
                $display("FAIL fetch_stall: iREN=%b ir=%h iaddr=%h want 1 %h %h", iREN, imemload, iaddr, exp_ir, exp_pc);
            end
        end
        ihit = 1'b1; iload = word;
        step();
        exp_ir = word;
        checks++;
        if (instr_valid !== 1'b1 || iREN !== 1'b0 || imemload !== exp_ir || iaddr !== exp_pc
            || pc_plus4 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL exec: valid=%b iREN=%b ir=%h iaddr=%h p4=%h want 1 0 %h %h %h",
                     instr_valid, iREN, imemload, iaddr, pc_plus4, exp_ir, exp_pc, exp_pc + 32'd4);
        end
        ihit = stray; iload = $urandom; PCSrc = src; beq = bq; zero = zr; jr_target = jt;
        mem_op = mop; halt = hlt;
        dhit = mop ? (nm == 0) : 1'($urandom);
        step();
        if (hlt) begin
            checks++;
            if (halted !== 1'b1 || iREN !== 1'b0 || instr_valid !== 1'b0 || iaddr !== exp_pc) begin
                errors++;
                $display("FAIL halt_entry: halted=%b iREN=%b valid=%b iaddr=%h want 1 0 0 %h",
                         halted, iREN, instr_valid, iaddr, exp_pc);
            end
            ihit = 1'b0; halt = 1'b0; mem_op = 1'b0;
            return;
        end
        if (mop && nm > 0) begin
            for (int k = 1; k <= nm; k++) begin
                checks++;
                if (instr_valid !== 1'b1 || iREN !== 1'b0 || imemload !== exp_ir || iaddr !== exp_pc) begin
                    errors++;
                    $display("FAIL mem_wait: valid=%b iREN=%b ir=%h iaddr=%h want 1 0 %h %h",
                             instr_valid, iREN, imemload, iaddr, exp_ir, exp_pc);
                end
                dhit = (k == nm); ihit = 1'($urandom);
                step();
            end
        end
        exp_pc = model_next(exp_pc, exp_ir, src, bq, zr, jt);
        checks++;
        if (iaddr !== exp_pc || iREN !== 1'b1 || instr_valid !== 1'b0 || imemload !== exp_ir) begin
            errors++;
            $display("FAIL commit: iaddr=%h iREN=%b valid=%b ir=%h want %h 1 0 %h",
                     iaddr, iREN, instr_valid, imemload, exp_pc, exp_ir);
        end
        ihit = 1'b0; halt = 1'b0; mem_op = 1'b0; dhit = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (iaddr !== 32'h0 || imemload !== 32'h0 || iREN !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: iaddr=%h ir=%h iREN=%b valid=%b halted=%b want 0 0 1 0 0",
                     iaddr, imemload, iREN, instr_valid, halted);
        end
    endtask

    task automatic test_seq();
        do_instr(32'h3421_0005, 0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_0004) begin
            errors++;
            $display("FAIL seq_first: iaddr=%h want 00000004", iaddr);
        end
    endtask

    task automatic test_branch();
        do_instr(32'h0000_0000, 0, 3'd3, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 0, 1'b0, 1'b0);
        do_instr(32'h1000_FFFF, 0, 3'd1, 1'b1, 1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_0010) begin errors++; $display("FAIL beq_taken: iaddr=%h want 00000010", iaddr); end
        do_instr(32'h1000_FFFF, 0, 3'd1, 1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_0014) begin errors++; $display("FAIL beq_not_taken: iaddr=%h want 00000014", iaddr); end
        do_instr(32'h0000_0000, 0, 3'd3, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 0, 1'b0, 1'b0);
        do_instr(32'h1400_FFFF, 0, 3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_0010) begin errors++; $display("FAIL bne_taken: iaddr=%h want 00000010", iaddr); end
    endtask

    task automatic test_jump();
        do_instr(32'h0000_0008, 0, 3'd3, 1'b0, 1'b0, 32'hF000_0000, 1'b0, 0, 1'b0, 1'b0);
        do_instr(32'h0800_0040, 0, 3'd2, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'hF000_0100) begin errors++; $display("FAIL jump: iaddr=%h want f0000100", iaddr); end
        do_instr(32'h0000_0008, 0, 3'd3, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_0123) begin errors++; $display("FAIL jr: iaddr=%h want 00000123", iaddr); end
    endtask

    task automatic test_mem_wait();
        logic [31:0] start_pc;
        start_pc = exp_pc;
        do_instr(32'h8C22_0000, 0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0, 1'b0);
        checks++;
        if (iaddr !== start_pc + 32'd4) begin errors++; $display("FAIL lw_commit: iaddr=%h want %h", iaddr, start_pc + 32'd4); end
    endtask

    task automatic test_fetch_stall();
        do_instr(32'h2002_0001, 5, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
        do_instr(32'hAC22_0004, 2, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 2, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        do_instr(32'h0000_0008, 0, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, 1'b0, 1'b0);
        do_instr(32'h0000_0000, 0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (iaddr !== 32'h0000_0000) begin errors++; $display("FAIL wrap: iaddr=%h want 00000000", iaddr); end
    endtask

    task automatic test_reset_mid_mem();
        do_instr(32'h0000_0008, 0, 3'd3, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 0, 1'b0, 1'b0);
        ihit = 1'b1; iload = 32'h8C01_0000;
        step();
        ihit = 1'b0; mem_op = 1'b1; dhit = 1'b0; PCSrc = 3'd0;
        step();
        checks++;
        if (instr_valid !== 1'b1 || iaddr !== 32'h0000_0040) begin
            errors++;
            $display("FAIL mid_mem: valid=%b iaddr=%h want 1 00000040", instr_valid, iaddr);
        end
        RST = 1'b1; dhit = 1'b1;
        step();
        RST = 1'b0; dhit = 1'b0; mem_op = 1'b0;
        exp_pc = PC_INIT; exp_ir = 32'h0;
        checks++;
        if (iaddr !== PC_INIT || imemload !== 32'h0 || iREN !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mem: iaddr=%h ir=%h iREN=%b valid=%b want %h 0 1 0",
                     iaddr, imemload, iREN, instr_valid, PC_INIT);
        end
    endtask

    task automatic test_halt();
        do_instr(32'h0000_000C, 1, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        do_instr(32'hFC00_0000, 0, 3'd3, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ihit = 1'($urandom); iload = $urandom; dhit = 1'($urandom); mem_op = 1'($urandom);
            halt = 1'($urandom); PCSrc = 3'($urandom); jr_target = $urandom;
            step();
            checks++;
            if (halted !== 1'b1 || iREN !== 1'b0 || instr_valid !== 1'b0 || iaddr !== exp_pc || imemload !== exp_ir) begin
                errors++;
                $display("FAIL halt_hold: halted=%b iREN=%b valid=%b iaddr=%h ir=%h want 1 0 0 %h %h",
                         halted, iREN, instr_valid, iaddr, imemload, exp_pc, exp_ir);
            end
        end
        RST = 1'b1;
        step();
        RST = 1'b0; ihit = 1'b0; halt = 1'b0; mem_op = 1'b0; dhit = 1'b0;
        exp_pc = PC_INIT; exp_ir = 32'h0;
        checks++;
        if (halted !== 1'b0 || iREN !== 1'b1 || iaddr !== PC_INIT || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset_from_halt: halted=%b iREN=%b iaddr=%h ir=%h want 0 1 %h 0",
                     halted, iREN, iaddr, imemload, PC_INIT);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            do_instr($urandom, $urandom_range(0, 2), 3'($urandom_range(0, 7)), 1'($urandom),
                     1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 3), 1'b0, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_mem_wait();
        test_fetch_stall();
        test_wrap();
        test_reset_mid_mem();
        test_random();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
